voting_machine_param: RTL

- Parametrised next-generation voting machine for N candidates.
- Per-candidate debounce and edge detection; one vote accepted per press; saturating per-candidate tallies.
- Separate vote and display modes; the display path shows a selected tally plus a registered winner/tie indication.
- Top-level block: buttons arrive from board switches; `result` drives LEDs.

---
 rtl/voting_machine_param_if.sv | 27 ++
 rtl/voting_machine_param.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/voting_machine_param_if.sv
// Board-side signal bundle for voting_machine_param: mode/buttons/select in,
// vote acknowledge, displayed tally and winner/status flags out.
interface voting_machine_param_if #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned IDX_W    = 2
);
  logic                mode;
  logic [NUM_CAND-1:0] cand_btn;
  logic [IDX_W-1:0]    sel;
  logic                vote_ack;
  logic [CNT_W-1:0]    result;
  logic [IDX_W-1:0]    winner_idx;
  logic                winner_tie;
  logic                sat;
  logic                lockout;

  modport master (
    output mode, cand_btn, sel,
    input  vote_ack, result, winner_idx, winner_tie, sat, lockout
  );

  modport slave (
    input  mode, cand_btn, sel,
    output vote_ack, result, winner_idx, winner_tie, sat, lockout
  );
endinterface

// File: rtl/voting_machine_param.sv
// Parametrised voting machine: per-button sync + debounce, one vote per press,
// saturating tallies, registered display and winner/tie indication.
module voting_machine_param #(
  parameter int unsigned NUM_CAND     = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned DEBOUNCE_CYC = 10
) (
  input logic                   clk,
  input logic                   rst,
  voting_machine_param_if.slave vm
);
  localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {StIdle, StLock} state_e;

  logic [NUM_CAND-1:0] r_sync1, r_sync2, r_db, r_db_prev, r_press, r_armed;
  logic [DB_W-1:0]     r_db_cnt [NUM_CAND];
  logic [1:0]          r_settle;
  logic [CNT_W-1:0]    r_tally  [NUM_CAND];
  state_e              r_state;
  logic                r_vote_ack, r_sat, r_lockout, r_winner_tie;
  logic [CNT_W-1:0]    r_result;
  logic [IDX_W-1:0]    r_winner_idx;

  logic [IDX_W-1:0]    w_press_idx, w_max_idx;
  logic [CNT_W-1:0]    w_max;
  logic                w_single, w_tie, w_seen, w_sel_ok;

  // A button held across reset stays unarmed until it is seen released after the
  // sync pipeline has refilled, so it cannot produce a vote on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      r_press   <= '0;
      r_armed   <= '0;
      r_settle  <= '0;
      r_db_cnt  <= '{default: '0};
    end else begin
      r_sync1   <= vm.cand_btn;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      r_press   <= r_db & ~r_db_prev & r_armed;
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      for (int unsigned i = 0; i < NUM_CAND; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
        if (r_settle == 2'd2 && !r_sync2[i] && !r_db[i]) r_armed[i] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_press_idx = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (r_press[i]) w_press_idx = IDX_W'(i);
    end
    w_single = (r_press != '0) && ((r_press & (r_press - NUM_CAND'(1))) == '0)
               && ((r_db & ~r_press) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_tally    <= '{default: '0};
      r_vote_ack <= 1'b0;
      r_sat      <= 1'b0;
      r_lockout  <= 1'b0;
    end else begin
      r_vote_ack <= 1'b0;
      case (r_state)
        StIdle: begin
          if (!vm.mode && (r_press != '0)) begin
            r_state   <= StLock;
            r_lockout <= 1'b1;
            if (w_single) begin
              r_vote_ack <= 1'b1;
              if (r_tally[w_press_idx] == CNT_MAX) r_sat <= 1'b1;
              else r_tally[w_press_idx] <= r_tally[w_press_idx] + CNT_W'(1);
            end
          end
        end
        StLock: begin
          if (r_db == '0) begin
            r_state   <= StIdle;
            r_lockout <= 1'b0;
          end
        end
        default: begin
          r_state   <= StIdle;
          r_lockout <= 1'b0;
        end
      endcase
    end
  end

  // Strict '>' keeps the lowest index on equal tallies.
  always_comb begin
    w_max     = '0;
    w_max_idx = '0;
    w_tie     = 1'b0;
    w_seen    = 1'b0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (r_tally[i] > w_max) begin
        w_max     = r_tally[i];
        w_max_idx = IDX_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      if (r_tally[i] == w_max) begin
        if (w_seen) w_tie = 1'b1;
        w_seen = 1'b1;
      end
    end
    if (w_max == '0) w_tie = 1'b0;
    w_sel_ok = (32'(vm.sel) < NUM_CAND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result     <= '0;
      r_winner_idx <= '0;
      r_winner_tie <= 1'b0;
    end else begin
      r_result     <= (vm.mode && w_sel_ok) ? r_tally[vm.sel] : '0;
      r_winner_idx <= w_max_idx;
      r_winner_tie <= w_tie;
    end
  end

  assign vm.vote_ack   = r_vote_ack;
  assign vm.result     = r_result;
  assign vm.winner_idx = r_winner_idx;
  assign vm.winner_tie = r_winner_tie;
  assign vm.sat        = r_sat;
  assign vm.lockout    = r_lockout;
endmodule
